serial_addsub: RTL and testbench

Bit-serial adder/subtractor that reuses a single full-adder/full-subtractor cell over WIDTH clock cycles, LSB first. It is the sequential stage built directly on the 1-bit full adder/subtractor cell. The block carries the carry or borrow between cycles in a flip-flop and produces a WIDTH-bit result with carry/borrow and signed-overflow flags. It uses a start/busy/done handshake toward the controlling logic.

---
 rtl/serial_addsub.sv | 132 +++++++++++++
 tb/tb_serial_addsub.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
//------------------------------------------------------------------------------
// Module      : serial_addsub
// Description : Bit-serial adder/subtractor, LSB first, one bit per clock,
//               with start/busy/done handshake, carry/borrow and overflow flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int              c_CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(WIDTH - 1);

    localparam logic [1:0]      c_IDLE  = 2'd0;
    localparam logic [1:0]      c_SHIFT = 2'd1;
    localparam logic [1:0]      c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sr;
    logic             r_mode;
    logic             r_c;
    logic [c_CW-1:0]  r_cnt;

    logic             w_x;
    logic             w_y;
    logic             w_bit;
    logic             w_cnext;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_next;

    // Full adder / full subtractor cell on the current LSBs
    assign w_x     = r_a[0];
    assign w_y     = r_b[0];
    assign w_bit   = w_x ^ w_y ^ r_c;
    assign w_cnext = r_mode ? ((~w_x & w_y) | (r_c & ~(w_x ^ w_y)))
                            : (( w_x & w_y) | (r_c &  (w_x ^ w_y)));
    assign w_last  = (r_cnt == c_LAST);

    generate
        if (WIDTH > 1) begin : g_wide
            assign w_sr_next = {w_bit, r_sr[WIDTH-1:1]};
        end else begin : g_narrow
            assign w_sr_next = w_bit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_SHIFT;
            c_SHIFT: if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_SHIFT);
        done = (r_state == c_DONE);
    end

    // On the last bit, r_c is the carry/borrow into the MSB, so overflow is
    // simply that value XOR the final carry/borrow out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sr   <= '0;
            r_mode <= 1'b0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_mode <= mode;
                        r_c    <= 1'b0;
                        r_cnt  <= '0;
                        r_sr   <= '0;
                    end
                end
                c_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_sr  <= w_sr_next;
                    r_c   <= w_cnext;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        result <= w_sr_next;
                        cout   <= w_cnext;
                        ovf    <= r_c ^ w_cnext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (WIDTH=8 and WIDTH=1).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_addsub;

    logic       clk;
    logic       rst;

    logic       start8, mode8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, res8;

    logic       start1, mode1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, res1;

    int errors;
    int checks;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one WIDTH=8 operation from IDLE; done must appear after edge k+8.
    task automatic run8(input logic m, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic ec, input logic eo);
        logic [7:0] prev;
        int lat, bcnt;
        bit held;
        prev = res8;
        held = 1'b1;
        @(negedge clk);
        a8 = x; b8 = y; mode8 = m; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 20) begin
            if (busy8) bcnt++;
            if (res8 !== prev) held = 1'b0;
            step();
            lat++;
        end
        chk("done_seen", done8, 1);
        chk("latency",   lat, 8);
        chk("busy_cyc",  bcnt, 8);
        chk("hold_shift", held, 1);
        chk("result",    res8, er);
        chk("cout",      cout8, ec);
        chk("ovf",       ovf8, eo);
        step();
        chk("done_pulse", done8, 0);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        start1 = 0; mode1 = 0; a1 = 0; b1 = 0;

        vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};

        step(); step();
        rst = 1'b0;
        chk("rst_busy",   busy8, 0);
        chk("rst_done",   done8, 0);
        chk("rst_result", res8, 0);
        chk("rst_cout",   cout8, 0);
        chk("rst_ovf",    ovf8, 0);
        chk("rst_result1", res1, 0);

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cout, vecs[i].ovf);
        end

        // start held high; operands change mid-operation
        begin
            int n;
            @(negedge clk);
            a8 = 8'h10; b8 = 8'h20; mode8 = 0; start8 = 1'b1;
            step();
            step(); step();
            a8 = 8'hAA; b8 = 8'h55;
            n = 0;
            while (!done8 && n < 20) begin step(); n++; end
            chk("hold_done", done8, 1);
            chk("hold_res1", res8, 8'h30);
            chk("hold_busy_done", busy8, 0);
            step();
            chk("hold_idle_busy", busy8, 0);
            chk("hold_idle_done", done8, 0);
            step();
            chk("hold_accept", busy8, 1);
            start8 = 1'b0;
            n = 0;
            while (!done8 && n < 20) begin step(); n++; end
            chk("hold_done2", done8, 1);
            chk("hold_res2", res8, 8'hFF);
            chk("hold_cout2", cout8, 0);
            step();
        end

        // reset during the 4th SHIFT cycle
        begin
            bit saw_done;
            @(negedge clk);
            a8 = 8'h35; b8 = 8'h4A; mode8 = 0; start8 = 1'b1;
            step();
            start8 = 1'b0;
            step(); step(); step();
            chk("pre_rst_busy", busy8, 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("mid_rst_busy",   busy8, 0);
            chk("mid_rst_done",   done8, 0);
            chk("mid_rst_result", res8, 0);
            chk("mid_rst_cout",   cout8, 0);
            chk("mid_rst_ovf",    ovf8, 0);
            saw_done = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (done8 || busy8) saw_done = 1'b1;
                step();
            end
            chk("no_done_after_rst", saw_done, 0);
            run8(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
        end

        // WIDTH=1 cell truth table, carry/borrow in = 0
        for (int k = 0; k < 8; k++) begin
            logic m, x, y, es, ec;
            int n;
            m = k[2]; x = k[1]; y = k[0];
            es = x ^ y;
            ec = m ? (~x & y) : (x & y);
            @(negedge clk);
            a1 = x; b1 = y; mode1 = m; start1 = 1'b1;
            step();
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            n = 0;
            while (!done1 && n < 10) begin step(); n++; end
            chk("w1_latency", n, 1);
            chk("w1_result", res1, es);
            chk("w1_cout", cout1, ec);
            chk("w1_ovf", ovf1, ec);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
